// File: rtl/fetch_pkg.sv
// Shared constants and the queued-entry type for the instruction-fetch buffer.
// With FETCH_MISALIGN_CHK_EN defined each entry also carries a misaligned flag.
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH = 2;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef struct packed {
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misaligned;
`endif
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with a combinational head read, a synchronous clear and
// occupancy count. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_MAX);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: tracks the 1-cycle imem read, queues {pc,inst} for decode and
// throttles the PC by credit. FETCH_MISALIGN_CHK_EN adds o_misaligned.
module fetch_buffer #(
  parameter int unsigned DEPTH    = fetch_pkg::FETCH_DEPTH,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_halt,
  input  logic        i_flush,
  output logic        o_stall,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        o_misaligned,
`endif
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] FULL_LVL = (CW+1)'(DEPTH);

  logic          req_vld_reg;
  logic [31:0]   req_pc_reg;
`ifdef FETCH_MISALIGN_CHK_EN
  logic          req_mis_reg;
`endif

  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   credit;

  assign o_valid = !empty;
  assign pop     = o_valid && i_ready;
  assign push    = req_vld_reg && !i_flush;

  // Occupancy the FIFO could reach next edge if the PC is allowed to issue now:
  // queued entries plus the in-flight read, minus what decode takes this cycle.
  assign credit  = {1'b0, count} + {{CW{1'b0}}, req_vld_reg} - {{CW{1'b0}}, pop};
  assign o_stall = (credit >= FULL_LVL);
  assign issue   = !i_halt && !o_stall && !i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_vld_reg <= 1'b0;
      req_pc_reg  <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      req_mis_reg <= 1'b0;
`endif
    end else begin
      req_vld_reg <= issue;
      if (issue) begin
        req_pc_reg  <= i_imem_raddr;
`ifdef FETCH_MISALIGN_CHK_EN
        req_mis_reg <= (i_imem_raddr[1:0] != 2'b00);
`endif
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = req_pc_reg;
    push_entry.inst = i_imem_rdata;
`ifdef FETCH_MISALIGN_CHK_EN
    push_entry.misaligned = req_mis_reg;
`endif
  end

  // Flush drives the FIFO clear, which takes priority over push and pop.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (i_flush),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    o_inst = NOP_INST;
    o_pc   = '0;
    if (o_valid) begin
      o_pc   = head_entry.pc;
      o_inst = head_entry.inst;
`ifdef FETCH_MISALIGN_CHK_EN
      if (head_entry.misaligned) o_inst = NOP_INST;
`endif
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign o_misaligned = o_valid && head_entry.misaligned;
`endif

  overflow_chk: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model checked every cycle,
// plus directed literal checks on the scenarios of interest.
`timescale 1ns/1ps
module tb_fetch_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_imem_raddr = '0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_halt  = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        o_misaligned;
`endif

  always #5 i_clk = ~i_clk;

  fetch_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_imem_raddr (i_imem_raddr),
    .i_imem_rdata (i_imem_rdata),
    .i_halt       (i_halt),
    .i_flush      (i_flush),
    .o_stall      (o_stall),
`ifdef FETCH_MISALIGN_CHK_EN
    .o_misaligned (o_misaligned),
`endif
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_inst       (o_inst),
    .o_pc         (o_pc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Reference model: an ordered list of delivered-but-unconsumed words plus
  // the one read that may be in flight.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          mis;
  } ent_t;

  ent_t        mq[$];
  bit          mreq_vld = 1'b0;
  logic [31:0] mreq_pc  = '0;
  bit          mreq_mis = 1'b0;
  bit          m_issued = 1'b0;

  always @(posedge i_clk or posedge i_rst) begin : model
    bit   mpop;
    bit   mstall;
    bit   missue;
    ent_t e;
    if (i_rst) begin
      mq.delete();
      mreq_vld <= 1'b0;
      mreq_pc  <= '0;
      mreq_mis <= 1'b0;
      m_issued <= 1'b0;
    end else begin
      mpop   = (mq.size() > 0) && i_ready;
      mstall = (mq.size() + int'(mreq_vld) - int'(mpop)) >= DEPTH;
      missue = !i_halt && !mstall && !i_flush;
      if (i_flush) begin
        mq.delete();
      end else begin
        if (mpop) void'(mq.pop_front());
        if (mreq_vld) begin
          e.pc   = mreq_pc;
          e.inst = i_imem_rdata;
          e.mis  = mreq_mis;
          mq.push_back(e);
        end
        tests++;
        if (mq.size() > DEPTH) begin
          fails++;
          $display("FAIL model_overflow: got %0d entries expected at most %0d", mq.size(), DEPTH);
        end
      end
      mreq_vld <= missue;
      if (missue) begin
        mreq_pc <= i_imem_raddr;
`ifdef FETCH_MISALIGN_CHK_EN
        mreq_mis <= (i_imem_raddr[1:0] != 2'b00);
`else
        mreq_mis <= 1'b0;
`endif
      end
      m_issued <= missue;
    end
  end

  always @(negedge i_clk) begin : cmp
    bit          ev;
    bit          epop;
    logic [31:0] ei;
    logic [31:0] ep;
    ev = mq.size() > 0;
    ei = NOP;
    ep = '0;
    if (ev) begin
      ep = mq[0].pc;
      ei = mq[0].mis ? NOP : mq[0].inst;
    end
    epop = ev && i_ready;
    check32("cyc_valid", 32'(o_valid), 32'(ev));
    check32("cyc_inst", o_inst, ei);
    check32("cyc_pc", o_pc, ep);
    check32("cyc_stall", 32'(o_stall),
            32'((mq.size() + int'(mreq_vld) - int'(epop)) >= DEPTH));
`ifdef FETCH_MISALIGN_CHK_EN
    check32("cyc_misaligned", 32'(o_misaligned), 32'(ev && mq[0].mis));
`endif
  end

  logic [31:0] pc = '0;
  logic [31:0] flush_tgt = '0;

  // Apply one cycle's controls, step the edge, then move the PC like the
  // real PC stage would (redirect on flush, advance on issue, else hold).
  task automatic cyc(input bit h, input bit f, input bit r, input logic [31:0] tgt);
    logic [31:0] prev;
    i_halt    = h;
    i_flush   = f;
    i_ready   = r;
    flush_tgt = tgt;
    @(posedge i_clk);
    #2;
    prev = i_imem_raddr;
    if (i_flush)       pc = flush_tgt;
    else if (m_issued) pc = pc + 32'd4;
    i_imem_raddr = pc;
    i_imem_rdata = imem(prev);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #2;
    check32("rst_valid", 32'(o_valid), 32'd0);
    check32("rst_inst", o_inst, 32'h0000_0013);
    check32("rst_pc", o_pc, 32'd0);
    check32("rst_stall", 32'(o_stall), 32'd0);
    i_rst = 1'b0;

    // Back-to-back stream, two-cycle latency.
    cyc(0, 0, 1, 0);
    check32("t1_latency", 32'(o_valid), 32'd0);
    cyc(0, 0, 1, 0);
    check32("t1_valid0", 32'(o_valid), 32'd1);
    check32("t1_pc0", o_pc, 32'h0000_0000);
    check32("t1_inst0", o_inst, 32'hC0DE_0000);
    cyc(0, 0, 1, 0);
    check32("t1_pc1", o_pc, 32'h0000_0004);
    check32("t1_inst1", o_inst, 32'hC0DE_0004);
    cyc(0, 0, 1, 0);
    check32("t1_pc2", o_pc, 32'h0000_0008);
    check32("t1_inst2", o_inst, 32'hC0DE_0008);
    check32("t1_stall", 32'(o_stall), 32'd0);

    // Flush with one queued and one in flight.
    cyc(0, 1, 1, 32'h100);
    check32("t4_valid", 32'(o_valid), 32'd0);
    check32("t4_inst", o_inst, 32'h0000_0013);

    // Decode not ready: fill to DEPTH and stall.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check32("t2_stall_a", 32'(o_stall), 32'd1);
    check32("t2_pc_a", o_pc, 32'h0000_0100);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check32("t2_stall_b", 32'(o_stall), 32'd1);
    check32("t2_pc_b", o_pc, 32'h0000_0100);
    check32("t2_inst_b", o_inst, 32'hC0DE_0100);

    // Single pop from full, then pop+push on the same edge.
    cyc(0, 0, 1, 0);
    check32("t3_pc_a", o_pc, 32'h0000_0104);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check32("t3_pc_b", o_pc, 32'h0000_0108);
    check32("t3_inst_b", o_inst, 32'hC0DE_0108);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

    // Redirect: first entry after flush is the new target's word.
    cyc(0, 1, 1, 32'h200);
    check32("t4b_valid", 32'(o_valid), 32'd0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check32("t4b_pc", o_pc, 32'h0000_0200);
    check32("t4b_inst", o_inst, 32'hC0DE_0200);

    // Halt for three cycles: in-flight word still delivered, then idle.
    cyc(1, 0, 1, 0);
    check32("t5_inflight_pc", o_pc, 32'h0000_0204);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    check32("t5_halt_idle", 32'(o_valid), 32'd0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check32("t5_resume_pc", o_pc, 32'h0000_0208);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset mid-stream.
    i_rst = 1'b1;
    #1;
    check32("t5_arst_valid", 32'(o_valid), 32'd0);
    check32("t5_arst_stall", 32'(o_stall), 32'd0);
    check32("t5_arst_pc", o_pc, 32'd0);
    check32("t5_arst_inst", o_inst, 32'h0000_0013);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    pc           = 32'h40;
    i_imem_raddr = pc;
    i_rst        = 1'b0;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check32("t5_post_rst_pc", o_pc, 32'h0000_0040);
    check32("t5_post_rst_inst", o_inst, 32'hC0DE_0040);

`ifdef FETCH_MISALIGN_CHK_EN
    cyc(0, 1, 1, 32'h6);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check32("t6_mis", 32'(o_misaligned), 32'd1);
    check32("t6_inst", o_inst, 32'h0000_0013);
    check32("t6_pc", o_pc, 32'h0000_0006);
    cyc(0, 1, 1, 32'h300);
`endif

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    @(posedge i_clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
